rr_arbiter_lock: RTL and testbench
==================================

// Module: rr_arbiter_lock
// PURPOSE
//   Parametrised round-robin arbiter with grant locking, for the slave-to-master and master-to-slave
//   paths of axi_interconnect. Takes NUM_REQ request lines and issues a registered one-hot grant.
//   The grant is held until the owner signals transfer completion, then rotates fairly.
//   Back-to-back handover has no idle bubble.
// PARAMETERS
//   NUM_REQ      4  number of requesters, 2..16
//   REL_ON_DROP  1  1: release the grant when the owner drops req without done; 0: hold until done
//   IDX_W        $clog2(NUM_REQ)  width of gnt_idx (derived, not overridden)
// PORTS
//   clk       in   1        rising-edge clock
//   rst_n     in   1        asynchronous active-low reset
//   req       in   NUM_REQ  request per requester; level, held until granted
//   done      in   1        owner's transaction complete (e.g. xVALID&xREADY&xLAST); ignored when gnt_vld=0
//   gnt       out  NUM_REQ  registered one-hot grant; all-zero when idle
//   gnt_idx   out  IDX_W    binary index of the gnt bit; 0 when idle
//   gnt_vld   out  1        |gnt, registered
// BEHAVIOUR
//   - Reset (async, rst_n=0): gnt=0, gnt_idx=0, gnt_vld=0, state=IDLE, last_ptr=NUM_REQ-1.
//     The outputs clear immediately, without waiting for clk.
//     After reset, requester 0 has the highest priority.
//   - Pick function rr(req,ptr): the first set bit scanning ptr+1, ptr+2, ... with modulo NUM_REQ wrap,
//     ending at ptr itself. This means the previous winner has the lowest priority but can still win.
//   - FSM, 2 states, with outputs registered:
//     IDLE: if |req then load gnt=onehot(rr(req,last_ptr)), set last_ptr=winner, go to LOCK.
//           Latency from req to gnt is 1 clk. If req is all-zero, stay in IDLE.
//     LOCK: gnt is held stable regardless of other req changes.
//       release = done | (REL_ON_DROP & ~req[gnt_idx]).
//       On release: if |req_eff then load the new winner rr(req_eff,gnt_idx) in the same edge with no bubble,
//         update last_ptr, and stay in LOCK. Otherwise set gnt=0 and go to IDLE.
//       req_eff = req, but with the owner's bit masked when the release was caused by a drop.
//   - done and a drop in the same cycle: treated as a single release.
//   - done while IDLE: no effect. done stuck high: with only the owner requesting, the grant is re-issued
//     to the same requester every cycle. With several requesters, the grant rotates every cycle.
//   - A new req arriving in the same cycle as a release takes part in that cycle's pick.
//   - Fairness: with all req high and done pulsed each transaction, the grant order is 0,1,..,NUM_REQ-1,0,...
//     No requester waits more than NUM_REQ-1 transactions once its req is asserted.
//   - gnt is always one-hot or zero. gnt_idx and gnt_vld are always consistent with gnt in the same cycle.
//   - Reset asserted mid-LOCK: the grant aborts immediately. The interconnect must drop the channel mux.
// STRUCTURE
//   - Package axi_ic_pkg: state enum {IDLE,LOCK}, function clog2, function onehot2idx.
//   - Sub-module rr_pick (combinational): inputs req[NUM_REQ] and ptr[IDX_W]; outputs onehot and idx.
//     Implemented with a double-width masked priority encode. rr_arbiter_lock instantiates one rr_pick.
//   - This block holds the FSM, last_ptr and the output registers.
// TESTING (NUM_REQ=4 unless noted)
//   1 Reset release, req=4'b1111, done pulsed on every 2nd cycle -> gnt sequence 0001,0010,0100,1000,0001.
//     Each grant is held exactly 2 cycles with no zero cycle between grants.
//   2 Only req[2] high, done pulsed -> gnt=0100 re-granted. Then req=0 with done -> gnt=0000 next cycle, FSM IDLE.
//   3 Grant 0001 held, req changes to 1110 with no done -> gnt stays 0001 (REL_ON_DROP=0).
//     With REL_ON_DROP=1, req[0] drops -> next gnt=0010.
//   4 Async reset asserted mid-LOCK between clock edges -> gnt=0 immediately.
//     After release, req=1000 -> gnt=1000 after 1 clk.
//   5 done asserted while IDLE with req=0 -> gnt stays 0, no pointer change.
//     Then req=0110 -> gnt=0010 (pointer still 3).
//   6 NUM_REQ=16, random req/done over 10k cycles -> assertions: onehot0(gnt), gnt stable unless a release occurs,
//     wait <= 15 grants per requester.

Source files
------------

// File: rtl/axi_ic_pkg.sv
// axi_ic_pkg: shared types and helpers for the interconnect arbiters
package axi_ic_pkg;
   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
   // Binary index of the set bit of a one-hot vector; 0 when the vector is empty
   function automatic logic [3:0] onehot2idx(input logic [15:0] oh);
      logic [3:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r = oh[i] ? r | 4'(i) : r;
      return r;
   endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick of the first request after ptr,
// wrapping around so ptr itself has the lowest priority
module rr_pick import axi_ic_pkg::*; #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_onehot,
   output logic [IDX_W-1:0]   o_idx
);
   logic [2*NUM_REQ-1:0] w_dbl;
   logic [2*NUM_REQ-1:0] w_first;
   // Upper copy supplies the wrapped-around candidates below and including ptr
   assign w_dbl    = {i_req, i_req} & ({(2*NUM_REQ){1'b1}} << (int'(i_ptr) + 1));
   assign w_first  = w_dbl & (-w_dbl);
   assign o_onehot = w_first[NUM_REQ-1:0] | w_first[2*NUM_REQ-1:NUM_REQ];
   assign o_idx    = IDX_W'(onehot2idx(16'(o_onehot)));
endmodule

// File: rtl/rr_arbiter_lock.sv
// rr_arbiter_lock: round-robin arbiter that locks the grant until the owner
// completes (or drops its request), then hands over with no idle cycle
module rr_arbiter_lock import axi_ic_pkg::*; #(
   parameter int NUM_REQ     = 4,
   parameter bit REL_ON_DROP = 1'b1,
   localparam int IDX_W      = clog2(NUM_REQ)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_done,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0]   o_gnt_idx,
   output logic               o_gnt_vld
);
   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_last_ptr;
   logic [IDX_W-1:0]   r_gnt_idx;
   logic [IDX_W-1:0]   w_ptr;
   logic [IDX_W-1:0]   w_pick_idx;
   logic [IDX_W-1:0]   w_gnt_idx_nxt;
   logic [NUM_REQ-1:0] r_gnt;
   logic [NUM_REQ-1:0] w_pick_req;
   logic [NUM_REQ-1:0] w_pick_oh;
   logic [NUM_REQ-1:0] w_gnt_nxt;
   logic               r_gnt_vld;
   logic               w_drop;
   logic               w_rel;
   logic               w_load;

   assign w_drop     = REL_ON_DROP && r_state == LOCK && !i_req[r_gnt_idx];
   assign w_rel      = r_state == LOCK && (i_done || w_drop);
   assign w_load     = r_state == IDLE || w_rel;
   assign w_ptr      = r_state == IDLE ? r_last_ptr : r_gnt_idx;
   // A dropping owner must not win its own handover
   assign w_pick_req = w_drop ? i_req & ~r_gnt : i_req;

   rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
      .i_req    (w_pick_req),
      .i_ptr    (w_ptr),
      .o_onehot (w_pick_oh),
      .o_idx    (w_pick_idx)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = w_load ? (|w_pick_oh ? LOCK : IDLE) : r_state;
   end

   always_comb begin
      w_gnt_nxt     = w_load ? w_pick_oh : r_gnt;
      w_gnt_idx_nxt = w_load ? w_pick_idx : r_gnt_idx;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_gnt      <= '0;
         r_gnt_idx  <= '0;
         r_gnt_vld  <= 1'b0;
         r_last_ptr <= IDX_W'(NUM_REQ - 1);
      end else begin
         r_gnt      <= w_gnt_nxt;
         r_gnt_idx  <= w_gnt_idx_nxt;
         r_gnt_vld  <= |w_gnt_nxt;
         r_last_ptr <= (w_load && |w_pick_oh) ? w_pick_idx : r_last_ptr;
      end
   end

   assign o_gnt     = r_gnt;
   assign o_gnt_idx = r_gnt_idx;
   assign o_gnt_vld = r_gnt_vld;
endmodule

// File: tb/tb_rr_arbiter_lock.sv
// tb_rr_arbiter_lock: scoreboard bench for rr_arbiter_lock (4-way with and without
// release-on-drop, plus a 16-way instance under random traffic against a model)
module tb_rr_arbiter_lock;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  req = '0;
   logic        done = 1'b0;
   logic [15:0] req16 = '0;
   logic        done16 = 1'b0;
   logic [3:0]  gnt_a, gnt_b;
   logic [1:0]  idx_a, idx_b;
   logic        vld_a, vld_b;
   logic [15:0] gnt_c;
   logic [3:0]  idx_c;
   logic        vld_c;

   typedef struct {
      int          sel;
      logic [15:0] exp;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   bit          rnd_on = 1'b0;
   logic [15:0] m_gnt;
   int          m_idx, m_last;
   bit          m_lock;

   always #5 clk = ~clk;

   rr_arbiter_lock #(.NUM_REQ(4), .REL_ON_DROP(1'b1)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_done(done),
      .o_gnt(gnt_a), .o_gnt_idx(idx_a), .o_gnt_vld(vld_a));
   rr_arbiter_lock #(.NUM_REQ(4), .REL_ON_DROP(1'b0)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_done(done),
      .o_gnt(gnt_b), .o_gnt_idx(idx_b), .o_gnt_vld(vld_b));
   rr_arbiter_lock #(.NUM_REQ(16), .REL_ON_DROP(1'b1)) u_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req16), .i_done(done16),
      .o_gnt(gnt_c), .o_gnt_idx(idx_c), .o_gnt_vld(vld_c));

   function automatic logic [3:0] idx_of(input logic [15:0] g);
      for (int i = 0; i < 16; i++) if (g[i]) return 4'(i);
      return 4'd0;
   endfunction

   function automatic int pick16(input logic [15:0] r, input int p);
      for (int k = 1; k <= 16; k++) if (r[(p + k) % 16]) return (p + k) % 16;
      return -1;
   endfunction

   task automatic check(input string name, input int sel, input logic [15:0] e);
      logic [15:0] g;
      logic [3:0]  ix;
      logic        v;
      g  = sel == 0 ? 16'(gnt_a) : sel == 1 ? 16'(gnt_b) : gnt_c;
      ix = sel == 0 ? 4'(idx_a) : sel == 1 ? 4'(idx_b) : idx_c;
      v  = sel == 0 ? vld_a : sel == 1 ? vld_b : vld_c;
      tests++;
      if (g !== e || ix !== idx_of(e) || v !== (|e)) begin
         fails++;
         $display("FAIL %s dut%0d @%0t: gnt=%h idx=%0d vld=%b, want gnt=%h idx=%0d vld=%b",
                  name, sel, $time, g, ix, v, e, idx_of(e), |e);
      end
   endtask

   // Monitor: drains the scoreboard once the grant of the current edge has settled
   always @(posedge clk) begin
      exp_t x;
      #1;
      while (sb.size() > 0) begin
         x = sb.pop_front();
         check(x.name, x.sel, x.exp);
      end
   end

   // Invariants on the 16-way instance, derived only from its inputs and outputs
   always @(posedge clk) begin
      logic [15:0] c_req;
      logic [15:0] c_prev;
      logic        c_done;
      logic        ld;
      int          wt[16];
      int          w;
      c_req  = req16;
      c_done = done16;
      #1;
      if (rnd_on) begin
         ld = c_prev == 16'd0 || c_done || (c_req & c_prev) == 16'd0;
         tests++;
         if (!$onehot0(gnt_c)) begin
            fails++;
            $display("FAIL onehot0 @%0t: gnt=%h", $time, gnt_c);
         end
         tests++;
         if (!ld && gnt_c !== c_prev) begin
            fails++;
            $display("FAIL stable @%0t: gnt=%h, want held %h", $time, gnt_c, c_prev);
         end
         if (ld && gnt_c != 16'd0) begin
            w = int'(idx_of(gnt_c));
            for (int i = 0; i < 16; i++) wt[i] = (i == w || !c_req[i]) ? 0 : wt[i] + 1;
            for (int i = 0; i < 16; i++) begin
               tests++;
               if (wt[i] > 15) begin
                  fails++;
                  $display("FAIL fairness @%0t: req%0d waited %0d grants, want <= 15", $time, i, wt[i]);
               end
            end
         end
      end else begin
         for (int i = 0; i < 16; i++) wt[i] = 0;
      end
      c_prev = gnt_c;
   end

   task automatic step(input logic [3:0] r, input logic d, input logic [3:0] ea,
                       input logic [3:0] eb, input string n);
      @(negedge clk);
      req  = r;
      done = d;
      sb.push_back('{sel: 0, exp: 16'(ea), name: n});
      sb.push_back('{sel: 1, exp: 16'(eb), name: n});
   endtask

   // Reset lands between edges so the async clear is checked before any clock
   task automatic do_reset(input string n);
      @(negedge clk);
      #1 rst_n = 1'b0;
      req = '0; done = 1'b0; req16 = '0; done16 = 1'b0;
      #1;
      for (int s = 0; s < 3; s++) check(n, s, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic rand_run(input int cycles);
      logic [15:0] nr;
      logic [15:0] re;
      int          w;
      m_gnt = '0; m_idx = 0; m_last = 15; m_lock = 1'b0;
      rnd_on = 1'b1;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         for (int i = 0; i < 16; i++)
            nr[i] = (m_lock && m_idx == i) ? ($urandom_range(0, 99) >= 10)
                                           : (req16[i] || $urandom_range(0, 99) < 20);
         req16  = nr;
         done16 = $urandom_range(0, 99) < 40;
         if (!m_lock) begin
            w = pick16(nr, m_last);
            if (w >= 0) begin
               m_gnt = 16'd1 << w; m_idx = w; m_last = w; m_lock = 1'b1;
            end
         end else if (done16 || !nr[m_idx]) begin
            re = !nr[m_idx] ? nr & ~m_gnt : nr;
            w  = pick16(re, m_idx);
            if (w >= 0) begin
               m_gnt = 16'd1 << w; m_idx = w; m_last = w;
            end else begin
               m_gnt = '0; m_idx = 0; m_lock = 1'b0;
            end
         end
         sb.push_back('{sel: 2, exp: m_gnt, name: "rand16"});
      end
      @(negedge clk);
      rnd_on = 1'b0;
   endtask

   initial begin
      do_reset("rst_init");
      step(4'b1111, 1'b0, 4'b0001, 4'b0001, "rot_g0");
      step(4'b1111, 1'b0, 4'b0001, 4'b0001, "rot_g0_hold");
      step(4'b1111, 1'b1, 4'b0010, 4'b0010, "rot_g1");
      step(4'b1111, 1'b0, 4'b0010, 4'b0010, "rot_g1_hold");
      step(4'b1111, 1'b1, 4'b0100, 4'b0100, "rot_g2");
      step(4'b1111, 1'b0, 4'b0100, 4'b0100, "rot_g2_hold");
      step(4'b1111, 1'b1, 4'b1000, 4'b1000, "rot_g3");
      step(4'b1111, 1'b0, 4'b1000, 4'b1000, "rot_g3_hold");
      step(4'b1111, 1'b1, 4'b0001, 4'b0001, "rot_wrap");
      step(4'b0000, 1'b1, 4'b0000, 4'b0000, "rot_to_idle");
      do_reset("rst_t2");
      step(4'b0100, 1'b0, 4'b0100, 4'b0100, "solo_grant");
      step(4'b0100, 1'b1, 4'b0100, 4'b0100, "solo_regrant");
      step(4'b0100, 1'b1, 4'b0100, 4'b0100, "solo_done_stuck");
      step(4'b0000, 1'b1, 4'b0000, 4'b0000, "solo_release");
      step(4'b0000, 1'b0, 4'b0000, 4'b0000, "solo_idle");
      step(4'b1011, 1'b0, 4'b1000, 4'b1000, "ptr_after_2");
      do_reset("rst_t3");
      step(4'b0001, 1'b0, 4'b0001, 4'b0001, "lock_grant");
      step(4'b1110, 1'b0, 4'b0010, 4'b0001, "lock_drop");
      step(4'b1110, 1'b0, 4'b0010, 4'b0001, "lock_hold");
      step(4'b1110, 1'b1, 4'b0100, 4'b0010, "lock_done");
      step(4'b0000, 1'b0, 4'b0000, 4'b0010, "drop_to_idle");
      step(4'b0000, 1'b1, 4'b0000, 4'b0000, "done_to_idle");
      do_reset("rst_t4");
      step(4'b1111, 1'b0, 4'b0001, 4'b0001, "pre_abort");
      step(4'b1111, 1'b0, 4'b0001, 4'b0001, "pre_abort_hold");
      do_reset("rst_midlock");
      step(4'b1000, 1'b0, 4'b1000, 4'b1000, "post_abort");
      do_reset("rst_t5");
      step(4'b0000, 1'b1, 4'b0000, 4'b0000, "idle_done");
      step(4'b0000, 1'b1, 4'b0000, 4'b0000, "idle_done2");
      step(4'b0110, 1'b0, 4'b0010, 4'b0010, "idle_ptr3");
      do_reset("rst_t6");
      step(4'b0001, 1'b0, 4'b0001, 4'b0001, "late_grant");
      step(4'b0100, 1'b1, 4'b0100, 4'b0100, "late_req_join");
      do_reset("rst_t7");
      step(4'b0101, 1'b1, 4'b0001, 4'b0001, "stuck_first");
      step(4'b0101, 1'b1, 4'b0100, 4'b0100, "stuck_rot1");
      step(4'b0101, 1'b1, 4'b0001, 4'b0001, "stuck_rot2");
      do_reset("rst_rand");
      rand_run(10000);
      @(negedge clk);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
